seg7_scan_display: RTL and testbench



---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/bin2bcd_seq.sv | 91 +++++++++
 rtl/seg7_scan_display.sv | 106 ++++++++++
 tb/tb_seg7_scan_display.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, conversion FSM state type and BCD-to-segment decoding
// for the multiplexed seven-segment display driver.
package seg7_pkg;

  // Segment patterns are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } conv_state_t;

  // Nibbles 10..15 cannot come out of the converter; show a dash if they ever do.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per cycle,
// with an up-front range check that skips the conversion for oversized values.
module bin2bcd_seq
  import seg7_pkg::*;
#(
  parameter int VALUE_W = 14,
  parameter int DIGITS  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [VALUE_W-1:0]    bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int          CNT_W   = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
  localparam logic [63:0] MAX_VAL = 64'(10**DIGITS - 1);

  conv_state_t         state_q, state_d;
  logic [VALUE_W-1:0]  shreg_q;
  logic [4*DIGITS-1:0] scratch_q, scratch_adj;
  logic [CNT_W-1:0]    cnt_q;
  logic                ovf_pend_q;
  logic                too_big;

  assign too_big = 64'(bin) > MAX_VAL;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = too_big ? COMMIT : SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == COMMIT);
  end

  // Pre-shift correction: any nibble >= 5 would become >= 10 after doubling.
  always_comb begin
    scratch_adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[4*d +: 4] >= 4'd5)
        scratch_adj[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shreg_q    <= bin;
            scratch_q  <= '0;
            cnt_q      <= CNT_W'(VALUE_W - 1);
            ovf_pend_q <= too_big;
          end
        end
        SHIFT: begin
          scratch_q <= {scratch_adj[4*DIGITS-2:0], shreg_q[VALUE_W-1]};
          shreg_q   <= shreg_q << 1;
          cnt_q     <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bcd = scratch_q;
  assign ovf = ovf_pend_q;

endmodule

// File: rtl/seg7_scan_display.sv
// Multi-digit common-anode seven-segment driver: converts a loaded binary value
// to BCD and time-multiplexes the digits with optional leading-zero blanking.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int VALUE_W     = 14,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [VALUE_W-1:0]  value,
  input  logic                load,
  input  logic                blank_lz,
  output logic [6:0]          seg,
  output logic [DIGITS-1:0]   an,
  output logic                busy,
  output logic                overflow
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                conv_busy, conv_done, conv_ovf;
  logic [4*DIGITS-1:0] conv_bcd, disp_q;
  logic                overflow_q;
  logic [PRE_W-1:0]    pre_q;
  logic [IDX_W-1:0]    idx_q;
  logic [DIGITS-1:0]   zero_from;
  logic                lz_run;
  logic [3:0]          cur_digit;
  logic [6:0]          seg_d;
  logic [DIGITS-1:0]   an_d;

  bin2bcd_seq #(
    .VALUE_W (VALUE_W),
    .DIGITS  (DIGITS)
  ) u_conv (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (load),
    .bin     (value),
    .busy    (conv_busy),
    .done    (conv_done),
    .bcd     (conv_bcd),
    .ovf     (conv_ovf)
  );

  // Display updates only on the converter's commit cycle, so it never shows
  // a half-converted number. On overflow the old digits are kept but hidden.
  // NOTE: the display register is reset too, so a reset always shows zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q     <= '0;
      overflow_q <= 1'b0;
    end else if (conv_done) begin
      overflow_q <= conv_ovf;
      if (!conv_ovf) disp_q <= conv_bcd;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_q <= '0;
      idx_q <= (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // zero_from[i] is set when digit i and every more-significant digit are zero.
  always_comb begin
    zero_from = '0;
    lz_run    = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz_run       = lz_run & (disp_q[4*i +: 4] == 4'd0);
      zero_from[i] = lz_run;
    end
    cur_digit   = disp_q[4*idx_q +: 4];
    an_d        = '1;
    an_d[idx_q] = 1'b0;
    if (overflow_q)
      seg_d = SEG_DASH;
    else if (blank_lz && (idx_q != '0) && zero_from[idx_q])
      seg_d = SEG_BLANK;
    else
      seg_d = bcd_to_seg(cur_digit);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg <= SEG_BLANK;
      an  <= '1;
    end else begin
      seg <= seg_d;
      an  <= an_d;
    end
  end

  assign busy     = conv_busy;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench: loads push a modelled expectation, a monitor checks busy
// length, overflow and the scanned digit patterns after each conversion.
module tb_seg7_scan_display;

  localparam int DIGITS      = 4;
  localparam int VALUE_W     = 14;
  localparam int REFRESH_DIV = 4;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               load = 1'b0;
  logic               blank_lz = 1'b0;
  logic [VALUE_W-1:0] value = '0;
  logic [6:0]         seg;
  logic [DIGITS-1:0]  an;
  logic               busy;
  logic               overflow;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .DIGITS      (DIGITS),
    .VALUE_W     (VALUE_W),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .value    (value),
    .load     (load),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .busy     (busy),
    .overflow (overflow)
  );

  typedef logic [DIGITS-1:0][6:0] segs_t;
  typedef struct {
    int    busy_len;
    bit    ovf;
    segs_t segs;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  int   pushed = 0;
  int   checked = 0;
  bit   expect_abort = 1'b0;

  logic [6:0] seg_table [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits by division; leading-zero test is "value < 10^i".
  function automatic segs_t model(input int v, input bit blank);
    segs_t s;
    int    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v > 9999)                     s[i] = 7'b0111111;
      else if (blank && i > 0 && v < p) s[i] = 7'b1111111;
      else                              s[i] = seg_table[(v / p) % 10];
      p = p * 10;
    end
    return s;
  endfunction

  task automatic scan_check(input segs_t exp, input string tag);
    logic [6:0]        got  [DIGITS];
    bit                seen [DIGITS];
    logic [DIGITS-1:0] pat;
    int                pos;
    int                invalid = 0;
    for (int i = 0; i < DIGITS; i++) begin
      got[i]  = 7'h00;
      seen[i] = 1'b0;
    end
    repeat (DIGITS * REFRESH_DIV + 4) begin
      @(negedge clk);
      pos = -1;
      for (int i = 0; i < DIGITS; i++) begin
        pat = ~(DIGITS'(1) << i);
        if (an === pat) pos = i;
      end
      if (pos < 0) invalid++;
      else begin
        got[pos]  = seg;
        seen[pos] = 1'b1;
      end
    end
    check($sformatf("%s_an_onehot", tag), invalid, 0);
    for (int i = 0; i < DIGITS; i++) begin
      check($sformatf("%s_seen%0d", tag, i), 32'(seen[i]), 1);
      check($sformatf("%s_digit%0d", tag, i), got[i], exp[i]);
    end
  endtask

  task automatic do_load(input int v, input bit push);
    exp_t e;
    @(negedge clk);
    value = VALUE_W'(v);
    load  = 1'b1;
    if (push) begin
      e.busy_len = (v > 9999) ? 1 : VALUE_W + 1;
      e.ovf      = (v > 9999);
      e.segs     = model(v, blank_lz);
      sb.push_back(e);
      pushed++;
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_checked();
    int n = 0;
    while (checked < pushed && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drain", checked, pushed);
  endtask

  initial begin : monitor
    exp_t e;
    int   blen;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        blen = 0;
        while (busy === 1'b1 && blen < 100) begin
          blen++;
          @(negedge clk);
        end
        if (expect_abort) begin
          expect_abort = 1'b0;
        end else if (sb.size() == 0) begin
          check("unexpected_busy", 1, 0);
        end else begin
          e = sb.pop_front();
          check("busy_len", blen, e.busy_len);
          check("overflow", 32'(overflow), 32'(e.ovf));
          scan_check(e.segs, "scan");
          checked++;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    logic [DIGITS-1:0] exp_an;
    int                v;

    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_seg", seg, 7'b1111111);
    check("reset_an", an, 4'b1111);
    check("reset_busy", 32'(busy), 0);
    check("reset_overflow", 32'(overflow), 0);

    #2 reset_n = 1'b1;
    for (int k = 1; k <= 4 * DIGITS; k++) begin
      @(negedge clk);
      exp_an = ~(DIGITS'(1) << (((k - 1) / REFRESH_DIV) % DIGITS));
      check("rst_scan_an", an, exp_an);
      check("rst_scan_seg", seg, 7'b1000000);
    end

    blank_lz = 1'b0;
    do_load(1234, 1'b1); wait_checked();

    blank_lz = 1'b1;
    do_load(7, 1'b1);    wait_checked();
    do_load(0, 1'b1);    wait_checked();
    do_load(1005, 1'b1); wait_checked();

    blank_lz = 1'b0;
    do_load(10000, 1'b1); wait_checked();
    do_load(9999, 1'b1);  wait_checked();

    // Second load lands three cycles after the first, mid-conversion.
    do_load(1234, 1'b1);
    @(negedge clk);
    do_load(5678, 1'b0);
    wait_checked();

    expect_abort = 1'b1;
    do_load(4321, 1'b0);
    repeat (4) @(negedge clk);
    check("pre_abort_busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_seg", seg, 7'b1111111);
    check("abort_an", an, 4'b1111);
    check("abort_busy", 32'(busy), 0);
    check("abort_overflow", 32'(overflow), 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    scan_check(model(0, 1'b0), "post_rst");

    repeat (12) begin
      v        = int'($urandom_range(0, 11000));
      blank_lz = 1'($urandom_range(0, 1));
      do_load(v, 1'b1);
      wait_checked();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
